// File: rtl/aspsa_engine_mc_if.sv
// Weight-update stream from the A-SPSA engine to the weight bank.
// The master drives one delta per valid/ready transfer; the slave is the bank.
interface aspsa_engine_mc_if #(
  parameter int unsigned WEIGHT_WIDTH = 16,
  parameter int unsigned CH_W         = 1
);
  logic                           weight_update_valid;
  logic                           weight_update_ready;
  logic [CH_W-1:0]                weight_ch;
  logic [15:0]                    weight_idx;
  logic signed [WEIGHT_WIDTH-1:0] weight_delta;

  modport master (
    output weight_update_valid, weight_ch, weight_idx, weight_delta,
    input  weight_update_ready
  );
  modport slave (
    input  weight_update_valid, weight_ch, weight_idx, weight_delta,
    output weight_update_ready
  );
endinterface

// File: rtl/aspsa_engine_mc.sv
// Multi-channel two-sided A-SPSA engine: +c sweep, -2c sweep, restore-and-step sweep per channel.
// Define ASPSA_GRAD_CLIP_EN to clip the gradient step to +/-STEP_MAX before forming deltas.
module aspsa_engine_mc #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned WEIGHT_WIDTH  = 16,
  parameter int unsigned NUM_WEIGHTS   = 1170,
  parameter int unsigned NUM_CH        = 2,
  parameter logic [31:0] LFSR_SEED     = 32'hDEADBEEF,
  parameter int unsigned ANNEAL_PERIOD = 100,
  parameter logic [15:0] LR_INIT       = 16'h1000,
  parameter logic [15:0] PERT_INIT     = 16'h0400,
  parameter logic [15:0] LR_MIN        = 16'h0010,
  parameter logic [15:0] PERT_MIN      = 16'h0040,
  parameter logic [15:0] STEP_MAX      = 16'h0200,
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         adapt_enable,
  input  logic                         temp_changed,
  input  logic signed [DATA_WIDTH-1:0] error_metric,
  input  logic [CH_W-1:0]              error_ch,
  input  logic                         error_valid,
  aspsa_engine_mc_if.master            wb,
  output logic                         busy,
  output logic [1:0]                   phase,
  output logic [15:0]                  learning_rate,
  output logic [15:0]                  perturb_size,
  output logic [31:0]                  lfsr_state,
  output logic [15:0]                  iteration_count
);
`ifdef ASPSA_GRAD_CLIP_EN
  localparam bit ClipEn = 1'b1;
`else
  localparam bit ClipEn = 1'b0;
`endif
  localparam int unsigned StepW = DATA_WIDTH + 2;
  localparam int unsigned ProdW = DATA_WIDTH + 18;
  localparam logic [31:0] LfsrTaps = 32'h80200003;
  localparam logic signed [31:0] StepLim = signed'({16'd0, STEP_MAX});
  localparam logic signed [31:0] WMax = (32'sd1 <<< (WEIGHT_WIDTH - 1)) - 32'sd1;
  localparam logic signed [31:0] WMin = -(32'sd1 <<< (WEIGHT_WIDTH - 1));

  // StStep is the one-cycle UPDATE entry where the multiply happens.
  typedef enum logic [2:0] {
    StIdle, StPertP, StWaitP, StPertM, StWaitM, StStep, StUpdate, StAnneal
  } state_e;

  state_e state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [15:0] c_lat_q, c_lat_d;
  logic [31:0] snap_q, snap_d, lfsr_q, lfsr_d, lfsr_adv;
  logic signed [DATA_WIDTH-1:0] e_p_q, e_p_d, e_m_q, e_m_d;
  logic signed [StepW-1:0] step_q, step_d, step_raw, step_new;
  logic valid_q, valid_d;
  logic [15:0] idx_q, idx_d;
  logic signed [WEIGHT_WIDTH-1:0] delta_q, delta_d;
  logic [15:0] lr_q [NUM_CH], lr_d [NUM_CH];
  logic [15:0] pert_q [NUM_CH], pert_d [NUM_CH];
  logic [15:0] acnt_q [NUM_CH], acnt_d [NUM_CH];
  logic [15:0] iter_q [NUM_CH], iter_d [NUM_CH];
  logic [1:0] phase_q, phase_d;
  logic busy_q;
  logic [15:0] lr_out_q, pert_out_q, iter_out_q;
  logic xfer, last;
  logic signed [DATA_WIDTH:0] diff;
  logic signed [ProdW-1:0] lr_ext, diff_ext, prod;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LfsrTaps) : (s >> 1);
  endfunction

  function automatic logic signed [WEIGHT_WIDTH-1:0] sat_w(input logic signed [31:0] v);
    if (v > WMax) return WMax[WEIGHT_WIDTH-1:0];
    if (v < WMin) return WMin[WEIGHT_WIDTH-1:0];
    return v[WEIGHT_WIDTH-1:0];
  endfunction

  // Magnitude per sweep, then applied with the perturbation sign (bit0 = 1 means +1).
  function automatic logic signed [WEIGHT_WIDTH-1:0] form_delta(
      input state_e st, input logic s, input logic [15:0] c, input logic signed [StepW-1:0] stp);
    logic signed [31:0] m;
    case (st)
      StPertP: m = signed'({16'd0, c});
      StPertM: m = -signed'({15'd0, c, 1'b0});
      default: m = signed'({16'd0, c}) - 32'(stp);
    endcase
    if (!s) m = -m;
    return sat_w(m);
  endfunction

  function automatic logic [15:0] decay(input logic [15:0] v, input logic [15:0] floor_v);
    logic [15:0] n;
    n = v - (v >> 4);
    return (n < floor_v) ? floor_v : n;
  endfunction

  always_comb begin
    diff     = {e_p_q[DATA_WIDTH-1], e_p_q} - {e_m_q[DATA_WIDTH-1], e_m_q};
    lr_ext   = signed'({{(DATA_WIDTH + 2){1'b0}}, lr_q[ch_q]});
    diff_ext = {{17{diff[DATA_WIDTH]}}, diff};
    prod     = lr_ext * diff_ext;
    step_raw = prod[ProdW-1:16];
    step_new = step_raw;
    if (ClipEn) begin
      if (32'(step_raw) > StepLim) step_new = StepW'(StepLim);
      else if (32'(step_raw) < -StepLim) step_new = StepW'(-StepLim);
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    c_lat_d  = c_lat_q;
    snap_d   = snap_q;
    lfsr_d   = lfsr_q;
    e_p_d    = e_p_q;
    e_m_d    = e_m_q;
    step_d   = step_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    delta_d  = delta_q;
    lr_d     = lr_q;
    pert_d   = pert_q;
    acnt_d   = acnt_q;
    iter_d   = iter_q;
    xfer     = valid_q & wb.weight_update_ready;
    last     = (idx_q == 16'(NUM_WEIGHTS - 1));
    lfsr_adv = lfsr_step(lfsr_q);

    unique case (state_q)
      StIdle: if (adapt_enable) begin
        state_d = StPertP;
        c_lat_d = pert_q[ch_q];
        snap_d  = lfsr_q;
        valid_d = 1'b1;
        idx_d   = '0;
        delta_d = form_delta(StPertP, lfsr_q[0], pert_q[ch_q], step_q);
      end
      StPertP, StPertM, StUpdate: if (xfer) begin
        lfsr_d = lfsr_adv;
        if (last) begin
          valid_d = 1'b0;
          state_d = (state_q == StPertP) ? StWaitP : (state_q == StPertM) ? StWaitM : StAnneal;
        end else begin
          idx_d   = idx_q + 16'd1;
          delta_d = form_delta(state_q, lfsr_adv[0], c_lat_q, step_q);
        end
      end
      StWaitP: if (error_valid && error_ch == ch_q) begin
        e_p_d   = error_metric;
        lfsr_d  = snap_q;
        state_d = StPertM;
        valid_d = 1'b1;
        idx_d   = '0;
        delta_d = form_delta(StPertM, snap_q[0], c_lat_q, step_q);
      end
      StWaitM: if (error_valid && error_ch == ch_q) begin
        e_m_d   = error_metric;
        lfsr_d  = snap_q;
        state_d = StStep;
      end
      StStep: begin
        step_d  = step_new;
        state_d = StUpdate;
        valid_d = 1'b1;
        idx_d   = '0;
        delta_d = form_delta(StUpdate, lfsr_q[0], c_lat_q, step_new);
      end
      StAnneal: begin
        if (iter_q[ch_q] != 16'hFFFF) iter_d[ch_q] = iter_q[ch_q] + 16'd1;
        if (32'(acnt_q[ch_q]) + 32'd1 >= ANNEAL_PERIOD) begin
          acnt_d[ch_q] = '0;
          lr_d[ch_q]   = decay(lr_q[ch_q], LR_MIN);
          pert_d[ch_q] = decay(pert_q[ch_q], PERT_MIN);
        end else begin
          acnt_d[ch_q] = acnt_q[ch_q] + 16'd1;
        end
        ch_d    = (32'(ch_q) == NUM_CH - 1) ? '0 : ch_q + CH_W'(1);
        state_d = StIdle;
      end
    endcase

    // Re-initialisation overrides any decay taken in the same cycle.
    if (temp_changed) begin
      for (int i = 0; i < NUM_CH; i++) begin
        lr_d[i]   = LR_INIT;
        pert_d[i] = PERT_INIT;
        acnt_d[i] = '0;
      end
    end

    unique case (state_d)
      StPertP:          phase_d = 2'd1;
      StPertM:          phase_d = 2'd2;
      StStep, StUpdate: phase_d = 2'd3;
      default:          phase_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ch_q       <= '0;
      c_lat_q    <= PERT_INIT;
      snap_q     <= LFSR_SEED;
      lfsr_q     <= LFSR_SEED;
      e_p_q      <= '0;
      e_m_q      <= '0;
      step_q     <= '0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      delta_q    <= '0;
      phase_q    <= 2'd0;
      busy_q     <= 1'b0;
      lr_out_q   <= LR_INIT;
      pert_out_q <= PERT_INIT;
      iter_out_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        lr_q[i]   <= LR_INIT;
        pert_q[i] <= PERT_INIT;
        acnt_q[i] <= '0;
        iter_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      c_lat_q    <= c_lat_d;
      snap_q     <= snap_d;
      lfsr_q     <= lfsr_d;
      e_p_q      <= e_p_d;
      e_m_q      <= e_m_d;
      step_q     <= step_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      delta_q    <= delta_d;
      phase_q    <= phase_d;
      busy_q     <= (state_d != StIdle);
      lr_out_q   <= lr_d[ch_d];
      pert_out_q <= pert_d[ch_d];
      iter_out_q <= iter_d[ch_d];
      lr_q       <= lr_d;
      pert_q     <= pert_d;
      acnt_q     <= acnt_d;
      iter_q     <= iter_d;
    end
  end

  assign wb.weight_update_valid = valid_q;
  assign wb.weight_ch           = ch_q;
  assign wb.weight_idx          = idx_q;
  assign wb.weight_delta        = delta_q;
  assign busy                   = busy_q;
  assign phase                  = phase_q;
  assign learning_rate          = lr_out_q;
  assign perturb_size           = pert_out_q;
  assign lfsr_state             = lfsr_q;
  assign iteration_count        = iter_out_q;
endmodule

// File: tb/tb_aspsa_engine_mc.sv
// Self-checking bench for aspsa_engine_mc: table vectors, hand-written corner sequences and
// randomized iterations compared against an arithmetic model of the SPSA schedule.
module tb_aspsa_engine_mc;
  localparam int NW  = 8;
  localparam int NCH = 2;
  localparam int AP  = 4;
  localparam logic [31:0] SEED = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst;
  logic adapt_enable, temp_changed, error_valid;
  logic signed [15:0] error_metric;
  logic [0:0] error_ch;
  logic busy;
  logic [1:0] phase;
  logic [15:0] learning_rate, perturb_size, iteration_count;
  logic [31:0] lfsr_state;

  aspsa_engine_mc_if #(.WEIGHT_WIDTH(16), .CH_W(1)) wbus ();

  aspsa_engine_mc #(
    .NUM_WEIGHTS  (NW),
    .NUM_CH       (NCH),
    .ANNEAL_PERIOD(AP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .adapt_enable   (adapt_enable),
    .temp_changed   (temp_changed),
    .error_metric   (error_metric),
    .error_ch       (error_ch),
    .error_valid    (error_valid),
    .wb             (wbus),
    .busy           (busy),
    .phase          (phase),
    .learning_rate  (learning_rate),
    .perturb_size   (perturb_size),
    .lfsr_state     (lfsr_state),
    .iteration_count(iteration_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_lfsr;
  longint m_lr [NCH];
  longint m_pert [NCH];
  int m_cnt [NCH];
  int m_iter [NCH];
  int m_ch;

  typedef struct {
    logic [15:0] ep;
    logic [15:0] em;
    int          step;
    bit          stall;
    bit          mism;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  function automatic logic signed [15:0] sat16(input longint v);
    if (v > 32767) return 16'sh7FFF;
    if (v < -32768) return 16'sh8000;
    return 16'(v);
  endfunction

  function automatic logic signed [15:0] exp_delta(input int ph, input bit s, input longint c,
                                                   input longint step);
    longint m;
    case (ph)
      1:       m = c;
      2:       m = -2 * c;
      default: m = c - step;
    endcase
    return sat16(s ? m : -m);
  endfunction

  function automatic int model_step(input logic [15:0] ep, input logic [15:0] em,
                                    input longint lr);
    longint d, st;
    d  = longint'($signed(ep)) - longint'($signed(em));
    st = (lr * d) >>> 16;
`ifdef ASPSA_GRAD_CLIP_EN
    if (st > 512) st = 512;
    if (st < -512) st = -512;
`endif
    return int'(st);
  endfunction

  task automatic model_reset();
    m_lfsr = SEED;
    m_ch   = 0;
    for (int i = 0; i < NCH; i++) begin
      m_lr[i] = 64'h1000; m_pert[i] = 64'h0400; m_cnt[i] = 0; m_iter[i] = 0;
    end
  endtask

  task automatic model_temp();
    for (int i = 0; i < NCH; i++) begin
      m_lr[i] = 64'h1000; m_pert[i] = 64'h0400; m_cnt[i] = 0;
    end
  endtask

  task automatic pulse_temp();
    temp_changed = 1'b1;
    @(negedge clk);
    temp_changed = 1'b0;
    model_temp();
    chk("temp_lr", 64'(learning_rate), 64'h1000);
  endtask

  // One full iteration starting from IDLE at a negedge; ends at a negedge back in IDLE.
  task automatic run_iter(input logic [15:0] ep, input logic [15:0] em, input int step,
                          input int rdy_pct, input bit stall, input bit mism, input bit temp_upd);
    longint c;
    logic [31:0] snap, lf;
    int n, cyc, hold;
    bit rdy, fire, tdone;
    c     = m_pert[m_ch];
    snap  = m_lfsr;
    tdone = 1'b0;
    adapt_enable = 1'b1;
    @(negedge clk);
    adapt_enable = 1'b0;
    for (int ph = 1; ph <= 3; ph++) begin
      lf = snap; n = 0; cyc = 0; hold = 0;
      while (n < NW && cyc < 100) begin
        rdy = ($urandom_range(0, 99) < rdy_pct);
        if (stall && ph == 2 && n == 3 && hold < 3) begin rdy = 1'b0; hold++; end
        wbus.weight_update_ready = rdy;
        chk("valid", 64'(wbus.weight_update_valid), 64'd1);
        chk("phase", 64'(phase), 64'(ph));
        chk("ch", 64'(wbus.weight_ch), 64'(m_ch));
        chk("idx", 64'(wbus.weight_idx), 64'(n));
        chk("delta", wbus.weight_delta, exp_delta(ph, lf[0], c, longint'(step)));
        chk("lfsr", 64'(lfsr_state), 64'(lf));
        if (rdy) begin lf = lfsr_next(lf); n++; end
        fire = temp_upd && ph == 3 && n == 4 && !tdone;
        if (fire) begin temp_changed = 1'b1; tdone = 1'b1; end
        @(negedge clk);
        cyc++;
        if (fire) begin
          temp_changed = 1'b0;
          model_temp();
          chk("temp_mid_update_lr", 64'(learning_rate), 64'h1000);
          chk("temp_mid_update_pert", 64'(perturb_size), 64'h0400);
        end
      end
      chk("sweep_len", 64'(n), 64'(NW));
      chk("sweep_end_valid", 64'(wbus.weight_update_valid), 64'd0);
      chk("sweep_end_busy", 64'(busy), 64'd1);
      if (ph < 3) begin
        chk("wait_phase", 64'(phase), 64'd0);
        if (mism && ph == 1) begin
          error_valid = 1'b1; error_ch = 1'(m_ch ^ 1); error_metric = 16'sh1234;
          @(negedge clk);
          error_valid = 1'b0;
          chk("wrong_ch_ignored_valid", 64'(wbus.weight_update_valid), 64'd0);
          chk("wrong_ch_ignored_phase", 64'(phase), 64'd0);
          chk("wrong_ch_ignored_busy", 64'(busy), 64'd1);
        end
        error_valid = 1'b1; error_ch = 1'(m_ch); error_metric = (ph == 1) ? ep : em;
        @(negedge clk);
        error_valid = 1'b0;
        if (ph == 2) begin
          chk("update_entry_valid", 64'(wbus.weight_update_valid), 64'd0);
          chk("update_entry_phase", 64'(phase), 64'd3);
          @(negedge clk);
        end
      end
    end
    @(negedge clk);
    chk("idle_after_anneal", 64'(busy), 64'd0);
    m_lfsr = lf;
    if (m_iter[m_ch] != 16'hFFFF) m_iter[m_ch]++;
    m_cnt[m_ch]++;
    if (m_cnt[m_ch] == AP) begin
      m_cnt[m_ch]  = 0;
      m_lr[m_ch]   = (m_lr[m_ch] - m_lr[m_ch] / 16 < 16) ? 16 : m_lr[m_ch] - m_lr[m_ch] / 16;
      m_pert[m_ch] = (m_pert[m_ch] - m_pert[m_ch] / 16 < 64) ? 64 :
                     m_pert[m_ch] - m_pert[m_ch] / 16;
    end
    m_ch = (m_ch + 1) % NCH;
    chk("next_ch", 64'(wbus.weight_ch), 64'(m_ch));
    chk("lr", 64'(learning_rate), 64'(m_lr[m_ch]));
    chk("pert", 64'(perturb_size), 64'(m_pert[m_ch]));
    chk("iter_count", 64'(iteration_count), 64'(m_iter[m_ch]));
    chk("lfsr_continue", 64'(lfsr_state), 64'(m_lfsr));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] ep, em;
    rst = 1'b1; adapt_enable = 1'b0; temp_changed = 1'b0; error_valid = 1'b0;
    error_metric = '0; error_ch = '0; wbus.weight_update_ready = 1'b1;
    model_reset();

    tbl[0] = '{16'h0200, 16'h0100, 16, 1'b0, 1'b1};
    tbl[1] = '{16'h0100, 16'h0200, -16, 1'b1, 1'b0};
    tbl[2] = '{16'h0000, 16'h0000, 0, 1'b0, 1'b0};
    tbl[3] = '{16'h0005, 16'h0000, 0, 1'b0, 1'b0};
    tbl[4] = '{16'h0000, 16'h0005, -1, 1'b0, 1'b0};
`ifdef ASPSA_GRAD_CLIP_EN
    tbl[5] = '{16'h7FFF, 16'h8000, 512, 1'b0, 1'b0};
    tbl[6] = '{16'h8000, 16'h7FFF, -512, 1'b0, 1'b0};
`else
    tbl[5] = '{16'h7FFF, 16'h8000, 4095, 1'b0, 1'b0};
    tbl[6] = '{16'h8000, 16'h7FFF, -4096, 1'b0, 1'b0};
`endif

    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(wbus.weight_update_valid), 64'd0);
    chk("rst_ch", 64'(wbus.weight_ch), 64'd0);
    chk("rst_idx", 64'(wbus.weight_idx), 64'd0);
    chk("rst_delta", 64'(wbus.weight_delta), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_phase", 64'(phase), 64'd0);
    chk("rst_lfsr", 64'(lfsr_state), 64'hDEADBEEF);
    chk("rst_lr", 64'(learning_rate), 64'h1000);
    chk("rst_pert", 64'(perturb_size), 64'h0400);
    chk("rst_iter", 64'(iteration_count), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table vectors, each from fresh annealing state (lr=0x1000, c=0x400).
    for (int i = 0; i < 7; i++) begin
      pulse_temp();
      run_iter(tbl[i].ep, tbl[i].em, tbl[i].step, 100, tbl[i].stall, tbl[i].mism, 1'b0);
    end

    // Annealing: 4 iterations on ch0 and 3 on ch1, then ch1's 4th.
    if (m_ch != 0) run_iter(16'h0, 16'h0, 0, 100, 1'b0, 1'b0, 1'b0);
    pulse_temp();
    for (int i = 0; i < 7; i++) run_iter(16'h0, 16'h0, 0, 70, 1'b0, 1'b0, 1'b0);
    chk("ch1_lr_undecayed", 64'(learning_rate), 64'h1000);
    chk("ch1_pert_undecayed", 64'(perturb_size), 64'h0400);
    run_iter(16'h0, 16'h0, 0, 70, 1'b0, 1'b0, 1'b0);
    chk("ch0_lr_decayed", 64'(learning_rate), 64'h0F00);
    chk("ch0_pert_decayed", 64'(perturb_size), 64'h03C0);
    // lr 0x0F00 * diff 0x100 >> 16 = 0xF; sweep keeps c_lat 0x3C0 across the temp pulse.
    run_iter(16'h0200, 16'h0100, 15, 100, 1'b0, 1'b0, 1'b1);

    // Randomized iterations against the model.
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) pulse_temp();
      ep = 16'($urandom);
      em = 16'($urandom);
      if ($urandom_range(0, 4) == 0) ep = 16'h7FFF;
      if ($urandom_range(0, 4) == 0) em = 16'h8000;
      run_iter(ep, em, model_step(ep, em, m_lr[m_ch]), 60, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b0);
    end

    // Asynchronous reset in the middle of a sweep.
    wbus.weight_update_ready = 1'b1;
    adapt_enable = 1'b1;
    @(negedge clk);
    adapt_enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(wbus.weight_update_valid), 64'd0);
    chk("async_rst_lfsr", 64'(lfsr_state), 64'hDEADBEEF);
    chk("async_rst_idx", 64'(wbus.weight_idx), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_iter", 64'(iteration_count), 64'd0);
    @(negedge clk);
    chk("async_rst_no_xfer", 64'(wbus.weight_update_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
